// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported architectural register file with a dedicated PC.
//
// After reset the block sweeps every storage entry to zero, one entry per
// cycle, then reports ready_o. While ready, it offers one write port and two
// registered read ports. The program counter lives in its own register
// (pc_q). Reads of PC_ID return that register.
//
// Ports:
//   clk_i     - clock, all state changes on the rising edge
//   rst_i     - synchronous active-high reset, restarts the clear sweep
//   ready_o   - high once the sweep is complete
//   we_i      - write enable
//   wr_id_i   - write register index
//   wr_dat_i  - write data
//   ra_id_i   - read port A index
//   ra_dat_o  - read port A data, one cycle after the index
//   rb_id_i   - read port B index
//   rb_dat_o  - read port B data, one cycle after the index
//   pc_inc_i  - advance PC by DAT_WIDTH/8
//   pc_o      - current PC, always valid
//
// Handshake: ready_o is a level, not a pulse. A write, a PC increment or a
// read index is accepted on any rising edge where ready_o is high. When
// ready_o is low, we_i and pc_inc_i are ignored and both read ports return 0.

`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

module regfile_mp #(
    parameter int                   DAT_WIDTH = `DAT_WIDTH,
    parameter int                   NREGS     = 32,
    parameter int                   PC_ID     = 31,
    parameter logic [DAT_WIDTH-1:0] PC_RESET  = DAT_WIDTH'(64'h800000000000),
    parameter bit                   ZERO_REG  = 1'b1,
    parameter bit                   BYPASS    = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       ready_o,
    input  logic                       we_i,
    input  logic [$clog2(NREGS)-1:0]   wr_id_i,
    input  logic [DAT_WIDTH-1:0]       wr_dat_i,
    input  logic [$clog2(NREGS)-1:0]   ra_id_i,
    output logic [DAT_WIDTH-1:0]       ra_dat_o,
    input  logic [$clog2(NREGS)-1:0]   rb_id_i,
    output logic [DAT_WIDTH-1:0]       rb_dat_o,
    input  logic                       pc_inc_i,
    output logic [DAT_WIDTH-1:0]       pc_o
);

    localparam int                ID_W    = $clog2(NREGS);
    localparam logic [ID_W:0]     NREGS_L = (ID_W + 1)'(NREGS);
    localparam logic [ID_W-1:0]   PC_IDX  = ID_W'(PC_ID);
    localparam logic [ID_W-1:0]   CNT_END = ID_W'(NREGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        cnt_q, cnt_d;
    logic [DAT_WIDTH-1:0]   pc_q, pc_d;
    logic [DAT_WIDTH-1:0]   ra_q, ra_d;
    logic [DAT_WIDTH-1:0]   rb_q, rb_d;
    logic [DAT_WIDTH-1:0]   mem_q [NREGS];

    // Storage write channel. During the sweep it carries the clearing writes,
    // and afterwards it carries accepted user writes.
    logic                   mem_we;
    logic [ID_W-1:0]        mem_idx;
    logic [DAT_WIDTH-1:0]   mem_val;
    // High when the user write lands in the array this cycle. It is used for
    // forwarding.
    logic                   wr_mem_hit;

    function automatic logic in_range(input logic [ID_W-1:0] id);
        return ({1'b0, id} < NREGS_L);
    endfunction

    // Next-state, PC and storage-write decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        mem_we     = 1'b0;
        mem_idx    = cnt_q;
        mem_val    = '0;
        wr_mem_hit = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we  = 1'b1;
                mem_idx = cnt_q;
                mem_val = '0;
                if (cnt_q == CNT_END) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                // PC_ID never touches the array, and index 0 is dropped when
                // it is hardwired to zero.
                wr_mem_hit = we_i && in_range(wr_id_i) && (wr_id_i != PC_IDX) &&
                             !(ZERO_REG && (wr_id_i == '0));
                mem_we  = wr_mem_hit;
                mem_idx = wr_id_i;
                mem_val = wr_dat_i;
                // An explicit PC write takes priority over an increment.
                if (we_i && (wr_id_i == PC_IDX)) begin
                    pc_d = wr_dat_i;
                end else if (pc_inc_i) begin
                    pc_d = pc_q + DAT_WIDTH'(DAT_WIDTH / 8);
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    function automatic logic [DAT_WIDTH-1:0] read_val(input logic [ID_W-1:0] id);
        logic [DAT_WIDTH-1:0] v;
        if (!in_range(id)) begin
            v = '0;
        end else if (ZERO_REG && (id == '0)) begin
            v = '0;
        end else if (id == PC_IDX) begin
            v = BYPASS ? pc_d : pc_q;
        end else if (BYPASS && wr_mem_hit && (wr_id_i == id)) begin
            v = wr_dat_i;
        end else begin
            v = mem_q[id];
        end
        return v;
    endfunction

    // Both read ports keep updating, including in cycles with a write.
    always_comb begin
        ra_d = '0;
        rb_d = '0;
        if (state_q == ST_READY) begin
            ra_d = read_val(ra_id_i);
            rb_d = read_val(rb_id_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            pc_q    <= PC_RESET;
            ra_q    <= '0;
            rb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
        end
    end

    // The array has no reset. The sweep defines its contents before ready_o
    // rises.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[mem_idx] <= mem_val;
        end
    end

    assign ready_o  = (state_q == ST_READY);
    assign ra_dat_o = ra_q;
    assign rb_dat_o = rb_q;
    assign pc_o     = pc_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp with default parameters.
// A behavioural model tracks register contents, the PC, and how many
// non-reset edges have passed since reset. It predicts ready_o, both read
// ports and pc_o after every clock edge.

module tb_regfile_mp;

  localparam int          DW       = 64;
  localparam int          NR       = 32;
  localparam int          PCI      = 31;
  localparam logic [63:0] PC_RST   = 64'h800000000000;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          ready_o;
  logic          we_i;
  logic [4:0]    wr_id_i;
  logic [DW-1:0] wr_dat_i;
  logic [4:0]    ra_id_i;
  logic [DW-1:0] ra_dat_o;
  logic [4:0]    rb_id_i;
  logic [DW-1:0] rb_dat_o;
  logic          pc_inc_i;
  logic [DW-1:0] pc_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [DW-1:0] m_mem [NR];
  logic [DW-1:0] m_pc;
  int            m_edges;

  regfile_mp #(
    .DAT_WIDTH(DW), .NREGS(NR), .PC_ID(PCI), .PC_RESET(PC_RST),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .ready_o(ready_o),
    .we_i(we_i), .wr_id_i(wr_id_i), .wr_dat_i(wr_dat_i),
    .ra_id_i(ra_id_i), .ra_dat_o(ra_dat_o),
    .rb_id_i(rb_id_i), .rb_dat_o(rb_dat_o),
    .pc_inc_i(pc_inc_i), .pc_o(pc_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Register value seen by a read this cycle: index 0 is zero, the PC index
  // sees the updated PC, and a same-cycle write is forwarded.
  function automatic logic [DW-1:0] mread(input logic [4:0] id, input logic we,
                                          input logic [4:0] wid, input logic [DW-1:0] wdat,
                                          input logic [DW-1:0] new_pc);
    if (id == 5'd0) return '0;
    if (int'(id) == PCI) return new_pc;
    if (we && wid == id) return wdat;
    return m_mem[id];
  endfunction

  // One clock: drive inputs, predict, take the edge, compare.
  task automatic cycle(input logic rst, input logic we, input logic [4:0] wid,
                       input logic [DW-1:0] wdat, input logic [4:0] ra,
                       input logic [4:0] rb, input logic inc, input string tag);
    logic [DW-1:0] e_ra, e_rb, new_pc;
    rst_i = rst; we_i = we; wr_id_i = wid; wr_dat_i = wdat;
    ra_id_i = ra; rb_id_i = rb; pc_inc_i = inc;
    e_ra = '0;
    e_rb = '0;
    if (rst) begin
      m_pc = PC_RST;
      m_edges = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_edges < NR) begin
      m_edges++;
    end else begin
      if (we && int'(wid) == PCI) new_pc = wdat;
      else if (inc)               new_pc = m_pc + 64'd8;
      else                        new_pc = m_pc;
      e_ra = mread(ra, we, wid, wdat, new_pc);
      e_rb = mread(rb, we, wid, wdat, new_pc);
      m_pc = new_pc;
      if (we && wid != 5'd0 && int'(wid) != PCI) m_mem[wid] = wdat;
    end
    @(posedge clk);
    #1;
    chk({tag, ".ready"}, {63'd0, ready_o}, {63'd0, (m_edges >= NR)});
    chk({tag, ".ra"}, ra_dat_o, e_ra);
    chk({tag, ".rb"}, rb_dat_o, e_rb);
    chk({tag, ".pc"}, pc_o, m_pc);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst_i = 1'b1; we_i = 1'b0; wr_id_i = '0; wr_dat_i = '0;
    ra_id_i = '0; rb_id_i = '0; pc_inc_i = 1'b0;
    m_pc = PC_RST; m_edges = 0;
    foreach (m_mem[i]) m_mem[i] = '0;

    // reset with random activity on the inputs
    repeat (3) cycle(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd64(),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), "rst");

    // clear sweep: writes and increments are ignored, ready rises on edge 32
    for (int i = 0; i < NR; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd64(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), "sweep");
    chk("ready_after_sweep", {63'd0, ready_o}, 64'd1);
    chk("pc_after_sweep", pc_o, 64'h800000000000);

    cycle(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd5, 1'b0, "rd_r5");
    chk("r5_zero", ra_dat_o, 64'd0);

    // write then dual read of the same register
    cycle(1'b0, 1'b1, 5'd3, 64'hDEADBEEF, 5'd0, 5'd0, 1'b0, "wr_r3");
    cycle(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd3, 1'b0, "rd_r3");
    chk("r3_a_const", ra_dat_o, 64'hDEADBEEF);
    chk("r3_b_const", rb_dat_o, 64'hDEADBEEF);

    // same-cycle write/read forwarding
    cycle(1'b0, 1'b1, 5'd7, 64'h55, 5'd7, 5'd3, 1'b0, "byp_r7");
    chk("r7_bypass_const", ra_dat_o, 64'h55);

    // hardwired zero register
    cycle(1'b0, 1'b1, 5'd0, 64'hFF, 5'd0, 5'd7, 1'b0, "wr_r0");
    cycle(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, "rd_r0");
    chk("r0_const", ra_dat_o, 64'd0);

    // PC load, increment, write-over-increment, wrap
    cycle(1'b0, 1'b1, 5'd31, 64'h1000, 5'd31, 5'd0, 1'b0, "pc_wr");
    repeat (3) cycle(1'b0, 1'b0, 5'd0, '0, 5'd31, 5'd31, 1'b1, "pc_inc");
    chk("pc_1018_const", pc_o, 64'h1018);
    chk("pc_read_const", ra_dat_o, 64'h1018);
    cycle(1'b0, 1'b1, 5'd31, 64'h2000, 5'd31, 5'd0, 1'b1, "pc_wr_inc");
    chk("pc_2000_const", pc_o, 64'h2000);
    cycle(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 5'd0, 1'b0, "pc_top");
    cycle(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd31, 1'b1, "pc_wrap");
    chk("pc_wrap_const", pc_o, 64'd0);

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd64(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0), "rand");

    // reset mid-sweep; writes during the sweep are lost
    cycle(1'b0, 1'b1, 5'd9, 64'hABCD, 5'd0, 5'd0, 1'b0, "wr_r9");
    cycle(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd0, 1'b0, "rd_r9");
    cycle(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, "rst2");
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 5'd9, rnd64(), 5'd9, 5'd9, 1'b1, "sweep2");
    cycle(1'b1, 1'b1, 5'd9, rnd64(), 5'd9, 5'd9, 1'b0, "rst_mid");
    for (int i = 0; i < NR; i++)
      cycle(1'b0, 1'b1, 5'd9, rnd64(), 5'd9, 5'd9, 1'($urandom_range(0, 1)), "sweep3");
    chk("ready_after_restart", {63'd0, ready_o}, 64'd1);
    chk("pc_after_restart", pc_o, 64'h800000000000);
    cycle(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd9, 1'b0, "rd_r9_clr");
    chk("r9_cleared_const", ra_dat_o, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
